// File: rtl/reg_scoreboard_if.sv
// Decode/writeback side-band bundle for the register scoreboard.
// The master is the decode/writeback side; the slave is the scoreboard.
interface reg_scoreboard_if #(
  parameter int unsigned N_REGS = 8
);
  localparam int unsigned AddrW = (N_REGS > 1) ? $clog2(N_REGS) : 1;

  logic             issue_valid;
  logic             src1_used;
  logic [AddrW-1:0] src1_addr;
  logic             src2_used;
  logic [AddrW-1:0] src2_addr;
  logic             dest_used;
  logic [AddrW-1:0] dest_addr;
  logic             wb_valid;
  logic [AddrW-1:0] wb_addr;
  logic             flush_valid;
  logic [AddrW-1:0] flush_addr;
  logic             stall;
  logic             issue_accept;
  logic [N_REGS-1:0] pending_mask;
  logic             underflow_err;

  modport master (
    output issue_valid, src1_used, src1_addr, src2_used, src2_addr,
    output dest_used, dest_addr, wb_valid, wb_addr, flush_valid, flush_addr,
    input  stall, issue_accept, pending_mask, underflow_err
  );

  modport slave (
    input  issue_valid, src1_used, src1_addr, src2_used, src2_addr,
    input  dest_used, dest_addr, wb_valid, wb_addr, flush_valid, flush_addr,
    output stall, issue_accept, pending_mask, underflow_err
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Per-register pending-write scoreboard: stalls decode on RAW hazards and on a
// saturated destination counter; writeback and flush retire pending writes.
module reg_scoreboard #(
  parameter int unsigned N_REGS = 8,
  parameter int unsigned CNT_W  = 2
) (
  input logic             clk,
  input logic             rst,
  reg_scoreboard_if.slave sb
);
  localparam int unsigned AddrW = (N_REGS > 1) ? $clog2(N_REGS) : 1;
  localparam int unsigned SumW  = CNT_W + 1;
  localparam logic [CNT_W-1:0] CMax = '1;

  logic [CNT_W-1:0]  count_q [N_REGS];
  logic [CNT_W-1:0]  count_d [N_REGS];
  logic              underflow_q, underflow_d;
  logic              hazard, stall, issue_accept;
  logic [N_REGS-1:0] mask;
  logic              under;
  logic [SumW-1:0]   inc, dec, total;

  // Hazard detection from current counts only; a same-cycle writeback does not bypass.
  always_comb begin
    hazard = 1'b0;
    if (sb.src1_used && (count_q[sb.src1_addr] != '0)) hazard = 1'b1;
    if (sb.src2_used && (count_q[sb.src2_addr] != '0)) hazard = 1'b1;
    if (sb.dest_used && (count_q[sb.dest_addr] == CMax)) hazard = 1'b1;
    stall        = sb.issue_valid & hazard;
    issue_accept = sb.issue_valid & ~hazard;
  end

  // Next counts: count + inc - dec in one extra bit, clamping negatives to zero.
  always_comb begin
    under = 1'b0;
    inc   = '0;
    dec   = '0;
    total = '0;
    for (int r = 0; r < N_REGS; r++) begin
      inc   = SumW'(issue_accept && sb.dest_used && (sb.dest_addr == AddrW'(r)));
      dec   = SumW'(sb.wb_valid && (sb.wb_addr == AddrW'(r)))
            + SumW'(sb.flush_valid && (sb.flush_addr == AddrW'(r)));
      total = SumW'(count_q[r]) + inc;
      if (total < dec) begin
        count_d[r] = '0;
        under      = 1'b1;
      end else begin
        // Issue stalls at CMax, so the difference always fits in CNT_W bits.
        count_d[r] = CNT_W'(total - dec);
      end
    end
    underflow_d = underflow_q | under;
  end

  // Pending mask is a pure function of the count registers.
  always_comb begin
    mask = '0;
    for (int r = 0; r < N_REGS; r++) begin
      mask[r] = (count_q[r] != '0);
    end
  end

  // Count and sticky error state; reset forgets every in-flight write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < N_REGS; r++) begin
        count_q[r] <= '0;
      end
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      underflow_q <= underflow_d;
    end
  end

  assign sb.stall         = stall;
  assign sb.issue_accept  = issue_accept;
  assign sb.pending_mask  = mask;
  assign sb.underflow_err = underflow_q;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed scenarios plus randomized
// traffic against a counter-array reference model.
module tb_reg_scoreboard;
  logic        clk;
  logic        rst;
  int unsigned n_pass;
  int unsigned n_total;
  int          cnt [8];
  bit          uerr_m;

  reg_scoreboard_if #(.N_REGS(8)) sb ();

  reg_scoreboard #(.N_REGS(8), .CNT_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: an instruction must wait while any source has a pending write,
  // or while its destination already has three outstanding writes.
  function automatic bit m_stall();
    bit h;
    h = 1'b0;
    if (sb.src1_used && cnt[sb.src1_addr] != 0) h = 1'b1;
    if (sb.src2_used && cnt[sb.src2_addr] != 0) h = 1'b1;
    if (sb.dest_used && cnt[sb.dest_addr] == 3) h = 1'b1;
    return sb.issue_valid && h;
  endfunction

  function automatic logic [7:0] m_mask();
    logic [7:0] m;
    for (int r = 0; r < 8; r++) m[r] = (cnt[r] != 0);
    return m;
  endfunction

  task automatic m_update();
    bit acc;
    int net;
    acc = sb.issue_valid && !m_stall();
    if (rst) begin
      for (int r = 0; r < 8; r++) cnt[r] = 0;
      uerr_m = 1'b0;
      return;
    end
    for (int r = 0; r < 8; r++) begin
      net = cnt[r];
      if (acc && sb.dest_used && sb.dest_addr == 3'(r)) net = net + 1;
      if (sb.wb_valid && sb.wb_addr == 3'(r)) net = net - 1;
      if (sb.flush_valid && sb.flush_addr == 3'(r)) net = net - 1;
      if (net < 0) begin
        net    = 0;
        uerr_m = 1'b1;
      end
      cnt[r] = net;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    m_update();
    @(negedge clk);
  endtask

  task automatic idle();
    sb.issue_valid = 1'b0;
    sb.src1_used   = 1'b0;
    sb.src1_addr   = '0;
    sb.src2_used   = 1'b0;
    sb.src2_addr   = '0;
    sb.dest_used   = 1'b0;
    sb.dest_addr   = '0;
    sb.wb_valid    = 1'b0;
    sb.wb_addr     = '0;
    sb.flush_valid = 1'b0;
    sb.flush_addr  = '0;
  endtask

  task automatic set_issue(bit s1u, int s1a, bit s2u, int s2a, bit du, int da);
    sb.issue_valid = 1'b1;
    sb.src1_used   = s1u;
    sb.src1_addr   = 3'(s1a);
    sb.src2_used   = s2u;
    sb.src2_addr   = 3'(s2a);
    sb.dest_used   = du;
    sb.dest_addr   = 3'(da);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    for (int r = 0; r < 8; r++) cnt[r] = 0;
    uerr_m = 1'b0;
    @(negedge clk);
    n_total++;
    if (sb.pending_mask !== 8'h00)
      $display("FAIL reset_mask: got %h expected 00", sb.pending_mask);
    else n_pass++;
    n_total++;
    if (sb.underflow_err !== 1'b0)
      $display("FAIL reset_uerr: got %b expected 0", sb.underflow_err);
    else n_pass++;
    set_issue(1, 3, 1, 4, 1, 3);
    #1;
    n_total++;
    if (sb.stall !== 1'b0 || sb.issue_accept !== 1'b1)
      $display("FAIL reset_comb: got stall=%b acc=%b expected stall=0 acc=1",
               sb.stall, sb.issue_accept);
    else n_pass++;
    tick();
    rst = 1'b0;
    idle();
    tick();
  endtask

  task automatic test_issue_basic();
    set_issue(0, 0, 0, 0, 1, 3);
    #1;
    n_total++;
    if (sb.issue_accept !== 1'b1)
      $display("FAIL basic_accept: got %b expected 1", sb.issue_accept);
    else n_pass++;
    tick();
    n_total++;
    if (sb.pending_mask !== 8'b0000_1000)
      $display("FAIL basic_mask: got %b expected 00001000", sb.pending_mask);
    else n_pass++;
    set_issue(1, 3, 0, 0, 0, 0);
    #1;
    n_total++;
    if (sb.stall !== 1'b1 || sb.issue_accept !== 1'b0)
      $display("FAIL basic_raw_stall: got stall=%b acc=%b expected stall=1 acc=0",
               sb.stall, sb.issue_accept);
    else n_pass++;
  endtask

  task automatic test_raw_release();
    // Dependent instruction on R3 still held from the previous task.
    sb.wb_valid = 1'b1;
    sb.wb_addr  = 3'd3;
    #1;
    n_total++;
    if (sb.stall !== 1'b1)
      $display("FAIL raw_same_cycle: got stall=%b expected 1", sb.stall);
    else n_pass++;
    tick();
    sb.wb_valid = 1'b0;
    #1;
    n_total++;
    if (sb.stall !== 1'b0 || sb.issue_accept !== 1'b1)
      $display("FAIL raw_next_cycle: got stall=%b acc=%b expected stall=0 acc=1",
               sb.stall, sb.issue_accept);
    else n_pass++;
    n_total++;
    if (sb.pending_mask !== 8'h00)
      $display("FAIL raw_mask: got %h expected 00", sb.pending_mask);
    else n_pass++;
    tick();
    idle();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 3; i++) begin
      set_issue(0, 0, 0, 0, 1, 5);
      #1;
      n_total++;
      if (sb.issue_accept !== 1'b1)
        $display("FAIL sat_issue%0d: got acc=%b expected 1", i, sb.issue_accept);
      else n_pass++;
      tick();
    end
    set_issue(0, 0, 0, 0, 1, 5);
    sb.wb_valid = 1'b1;
    sb.wb_addr  = 3'd5;
    #1;
    n_total++;
    if (sb.stall !== 1'b1)
      $display("FAIL sat_full_stall: got stall=%b expected 1", sb.stall);
    else n_pass++;
    tick();
    sb.wb_valid = 1'b0;
    #1;
    n_total++;
    if (sb.issue_accept !== 1'b1)
      $display("FAIL sat_retry_accept: got acc=%b expected 1", sb.issue_accept);
    else n_pass++;
    tick();
    idle();
    sb.wb_valid = 1'b1;
    sb.wb_addr  = 3'd5;
    for (int i = 0; i < 3; i++) begin
      n_total++;
      if (sb.pending_mask !== 8'h20)
        $display("FAIL sat_drain%0d: got %h expected 20", i, sb.pending_mask);
      else n_pass++;
      tick();
    end
    idle();
    n_total++;
    if (sb.pending_mask !== 8'h00 || sb.underflow_err !== 1'b0)
      $display("FAIL sat_empty: got mask=%h uerr=%b expected mask=00 uerr=0",
               sb.pending_mask, sb.underflow_err);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    set_issue(0, 0, 0, 0, 1, 2);
    tick();
    tick();
    sb.wb_valid    = 1'b1;
    sb.wb_addr     = 3'd2;
    sb.flush_valid = 1'b1;
    sb.flush_addr  = 3'd2;
    #1;
    n_total++;
    if (sb.issue_accept !== 1'b1)
      $display("FAIL simul_accept: got acc=%b expected 1", sb.issue_accept);
    else n_pass++;
    tick();
    sb.flush_valid = 1'b0;
    n_total++;
    if (sb.pending_mask !== 8'h04)
      $display("FAIL simul_net_minus1: got %h expected 04", sb.pending_mask);
    else n_pass++;
    tick();
    idle();
    n_total++;
    if (sb.pending_mask !== 8'h04)
      $display("FAIL simul_issue_wb: got %h expected 04", sb.pending_mask);
    else n_pass++;
    // A single writeback must now empty R2 without underflow, proving count was 1.
    sb.wb_valid = 1'b1;
    sb.wb_addr  = 3'd2;
    tick();
    idle();
    n_total++;
    if (sb.pending_mask !== 8'h00 || sb.underflow_err !== 1'b0)
      $display("FAIL simul_count_one: got mask=%h uerr=%b expected mask=00 uerr=0",
               sb.pending_mask, sb.underflow_err);
    else n_pass++;
  endtask

  task automatic test_underflow();
    sb.wb_valid = 1'b1;
    sb.wb_addr  = 3'd7;
    tick();
    idle();
    n_total++;
    if (sb.underflow_err !== 1'b1 || sb.pending_mask !== 8'h00)
      $display("FAIL underflow_set: got uerr=%b mask=%h expected uerr=1 mask=00",
               sb.underflow_err, sb.pending_mask);
    else n_pass++;
    for (int i = 0; i < 3; i++) tick();
    n_total++;
    if (sb.underflow_err !== 1'b1)
      $display("FAIL underflow_sticky: got %b expected 1", sb.underflow_err);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    set_issue(0, 0, 0, 0, 1, 1);
    tick();
    set_issue(0, 0, 0, 0, 1, 4);
    tick();
    idle();
    n_total++;
    if (sb.pending_mask !== 8'h12)
      $display("FAIL async_pre_mask: got %h expected 12", sb.pending_mask);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_total++;
    if (sb.pending_mask !== 8'h00 || sb.underflow_err !== 1'b0)
      $display("FAIL async_clear: got mask=%h uerr=%b expected mask=00 uerr=0",
               sb.pending_mask, sb.underflow_err);
    else n_pass++;
    for (int r = 0; r < 8; r++) cnt[r] = 0;
    uerr_m = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_random();
    int pick;
    for (int cyc = 0; cyc < 300; cyc++) begin
      set_issue($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 1),
                $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 3));
      sb.issue_valid = ($urandom_range(0, 3) != 0);
      // Bias writebacks/flushes toward registers that actually have pending writes.
      pick = $urandom_range(0, 7);
      for (int k = 0; k < 8; k++) if (cnt[(pick + k) % 8] != 0) begin
        pick = (pick + k) % 8;
        break;
      end
      sb.wb_valid    = ($urandom_range(0, 9) < 4);
      sb.wb_addr     = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(0, 7)) : 3'(pick);
      sb.flush_valid = ($urandom_range(0, 9) == 0);
      sb.flush_addr  = 3'(pick);
      #1;
      n_total++;
      if (sb.stall !== m_stall())
        $display("FAIL rand_stall@%0d: got %b expected %b", cyc, sb.stall, m_stall());
      else n_pass++;
      n_total++;
      if (sb.issue_accept !== (sb.issue_valid && !m_stall()))
        $display("FAIL rand_accept@%0d: got %b expected %b", cyc, sb.issue_accept,
                 sb.issue_valid && !m_stall());
      else n_pass++;
      tick();
      n_total++;
      if (sb.pending_mask !== m_mask())
        $display("FAIL rand_mask@%0d: got %h expected %h", cyc, sb.pending_mask, m_mask());
      else n_pass++;
      n_total++;
      if (sb.underflow_err !== uerr_m)
        $display("FAIL rand_uerr@%0d: got %b expected %b", cyc, sb.underflow_err, uerr_m);
      else n_pass++;
    end
    idle();
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_issue_basic();
    test_raw_release();
    test_saturation();
    test_simultaneous();
    test_underflow();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
